// File: rtl/title_fade_pkg.sv
// ---------------------------------------------------------------------------
// title_pkg
//   Shared types and helpers for the title-screen fade stage.
//   - fade_state_t : fade sequencer states
//   - LEVEL_MAX    : full brightness level
//   - scale_px     : brightness scaling of one 4-bit colour channel
// ---------------------------------------------------------------------------
package title_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_IN  = 3'd1,
    HOLD     = 3'd2,
    FADE_OUT = 3'd3,
    DONE     = 3'd4
  } fade_state_t;

  localparam logic [3:0] LEVEL_MAX = 4'd15;

  // Level 0 is forced black; otherwise in*(level+1)/16 with an 8-bit product,
  // so level 15 reproduces the input exactly.
  function automatic logic [3:0] scale_px(input logic [3:0] px, input logic [3:0] lvl);
    logic [3:0] res;
    if (lvl == 4'd0) begin
      res = 4'd0;
    end else begin
      res = 4'(({4'd0, px} * ({4'd0, lvl} + 8'd1)) >> 4);
    end
    return res;
  endfunction

endpackage

// File: rtl/title_fade_scale.sv
// ---------------------------------------------------------------------------
// fade_scale
//   Combinational brightness scaler for one colour channel.
//   Ports:
//     i_in    in  4  colour value from the renderer
//     i_level in  4  brightness level 0..15
//     o_out   out 4  scaled colour value
// ---------------------------------------------------------------------------
module fade_scale
  import title_pkg::*;
(
  input  logic [3:0] i_in,
  input  logic [3:0] i_level,
  output logic [3:0] o_out
);

  assign o_out = scale_px(i_in, i_level);

endmodule

// File: rtl/title_fade.sv
// ---------------------------------------------------------------------------
// title_fade
//   Title-screen brightness stage: fades the renderer RGB in from black,
//   holds at full brightness until the player confirms, fades out, then
//   signals title_done. Paced by vsync falling edges (frame ticks).
//   Ports:
//     vga_clk    in   1  pixel clock
//     reset_n    in   1  asynchronous active-low reset
//     vs         in   1  VGA vsync (active-low)
//     start      in   1  pulse: begin fade-in (from IDLE or DONE)
//     skip       in   1  pulse: jump to the end of the current fade
//     key_go     in   1  pulse: player confirm, begins fade-out from HOLD
//     in_red/in_green/in_blue  in 4  renderer colour
//     red/green/blue           out 4 scaled colour, registered
//     level      out  4  current brightness
//     busy       out  1  high in FADE_IN, HOLD, FADE_OUT
//     title_done out  1  high in DONE
// ---------------------------------------------------------------------------
module title_fade
  import title_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4,
  parameter int HOLD_FRAMES     = 60
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       vs,
  input  logic       start,
  input  logic       skip,
  input  logic       key_go,
  input  logic [3:0] in_red,
  input  logic [3:0] in_green,
  input  logic [3:0] in_blue,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [3:0] level,
  output logic       busy,
  output logic       title_done
);

  localparam int STEP_W = $clog2(FRAMES_PER_STEP + 1);
  // $clog2(1) is 0, so a zero hold still needs a 1-bit counter.
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_ZERO = STEP_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

  fade_state_t       r_state, w_state_nxt;
  logic [3:0]        r_level, w_level_nxt;
  logic [STEP_W-1:0] r_step_cnt, w_step_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic              r_vs_q;
  logic              r_busy, r_done;
  logic              w_busy_nxt, w_done_nxt;
  logic              w_tick;
  logic [3:0]        r_red, r_green, r_blue;
  logic [3:0]        w_red, w_green, w_blue;

  // One-cycle pulse on the vsync falling edge; a held-low vs yields one tick.
  assign w_tick = r_vs_q & ~vs;

  fade_scale u_scale_r (.i_in(in_red),   .i_level(r_level), .o_out(w_red));
  fade_scale u_scale_g (.i_in(in_green), .i_level(r_level), .o_out(w_green));
  fade_scale u_scale_b (.i_in(in_blue),  .i_level(r_level), .o_out(w_blue));

  // vsync history register for edge detection.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_q <= 1'b1;
    end else begin
      r_vs_q <= vs;
    end
  end

  // Sequencer state, counters and registered status outputs.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_level    <= 4'd0;
      r_step_cnt <= STEP_ZERO;
      r_hold_cnt <= HOLD_ZERO;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_step_cnt <= w_step_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state logic; skip is checked before tick so it always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_step_nxt  = r_step_cnt;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      IDLE, DONE: begin
        w_level_nxt = 4'd0;
        // A tick arriving with start is not counted: step_cnt restarts at 0.
        if (start) begin
          w_state_nxt = FADE_IN;
          w_step_nxt  = STEP_ZERO;
        end else begin
          w_state_nxt = r_state;
        end
      end
      FADE_IN: begin
        if (skip) begin
          w_level_nxt = LEVEL_MAX;
          w_state_nxt = HOLD;
          w_hold_nxt  = HOLD_ZERO;
        end else if (w_tick) begin
          if (r_step_cnt == STEP_LAST) begin
            w_step_nxt  = STEP_ZERO;
            w_level_nxt = r_level + 4'd1;
            if (r_level == (LEVEL_MAX - 4'd1)) begin
              w_state_nxt = HOLD;
              w_hold_nxt  = HOLD_ZERO;
            end else begin
              w_state_nxt = FADE_IN;
            end
          end else begin
            w_step_nxt = r_step_cnt + STEP_ONE;
          end
        end else begin
          w_state_nxt = FADE_IN;
        end
      end
      HOLD: begin
        w_level_nxt = LEVEL_MAX;
        if (key_go && (r_hold_cnt == HOLD_SAT)) begin
          w_state_nxt = FADE_OUT;
          w_step_nxt  = STEP_ZERO;
        end else if (w_tick && (r_hold_cnt != HOLD_SAT)) begin
          w_hold_nxt = r_hold_cnt + HOLD_ONE;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      FADE_OUT: begin
        if (skip) begin
          w_level_nxt = 4'd0;
          w_state_nxt = DONE;
        end else if (w_tick) begin
          if (r_step_cnt == STEP_LAST) begin
            w_step_nxt  = STEP_ZERO;
            w_level_nxt = r_level - 4'd1;
            if (r_level == 4'd1) begin
              w_state_nxt = DONE;
            end else begin
              w_state_nxt = FADE_OUT;
            end
          end else begin
            w_step_nxt = r_step_cnt + STEP_ONE;
          end
        end else begin
          w_state_nxt = FADE_OUT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_level_nxt = 4'd0;
        w_step_nxt  = STEP_ZERO;
        w_hold_nxt  = HOLD_ZERO;
      end
    endcase
    w_busy_nxt = (w_state_nxt == FADE_IN) || (w_state_nxt == HOLD) || (w_state_nxt == FADE_OUT);
    w_done_nxt = (w_state_nxt == DONE);
  end

  // Registered pixel outputs, always passed through the scaler.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_red   <= 4'd0;
      r_green <= 4'd0;
      r_blue  <= 4'd0;
    end else begin
      r_red   <= w_red;
      r_green <= w_green;
      r_blue  <= w_blue;
    end
  end

  assign red        = r_red;
  assign green      = r_green;
  assign blue       = r_blue;
  assign level      = r_level;
  assign busy       = r_busy;
  assign title_done = r_done;

endmodule

// File: tb/tb_title_fade.sv
// ---------------------------------------------------------------------------
// tb_title_fade
//   Directed self-checking bench for title_fade with FRAMES_PER_STEP=2,
//   HOLD_FRAMES=3 and a 20-clock vsync frame.
// ---------------------------------------------------------------------------
module tb_title_fade;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       vs;
  logic       start, skip, key_go;
  logic [3:0] in_red, in_green, in_blue;
  logic [3:0] red, green, blue, level;
  logic       busy, title_done;

  int n_cmp = 0;
  int n_mis = 0;

  title_fade #(.FRAMES_PER_STEP(2), .HOLD_FRAMES(3)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .vs(vs),
    .start(start), .skip(skip), .key_go(key_go),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .red(red), .green(green), .blue(blue),
    .level(level), .busy(busy), .title_done(title_done)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n frames: vs low 3 clk, high 17 clk; returns at a falling clock edge
  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge vga_clk); vs = 1'b0;
      repeat (3) @(negedge vga_clk);
      vs = 1'b1;
      repeat (16) @(negedge vga_clk);
    end
  endtask

  task automatic pulse_start;
    @(negedge vga_clk); start = 1'b1;
    @(negedge vga_clk); start = 1'b0;
  endtask

  task automatic pulse_skip;
    @(negedge vga_clk); skip = 1'b1;
    @(negedge vga_clk); skip = 1'b0;
  endtask

  task automatic pulse_go;
    @(negedge vga_clk); key_go = 1'b1;
    @(negedge vga_clk); key_go = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; vs = 1'b1; start = 1'b0; skip = 1'b0; key_go = 1'b0;
    in_red = 4'hF; in_green = 4'h8; in_blue = 4'h1;
    #1;
    chk("rst_level", level, 8'd0);
    chk("rst_busy", busy, 8'd0);
    chk("rst_red", red, 8'd0);
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;

    // 1: idle, outputs black
    repeat (100) @(negedge vga_clk);
    chk("idle_red", red, 8'd0);
    chk("idle_green", green, 8'd0);
    chk("idle_level", level, 8'd0);
    chk("idle_busy", busy, 8'd0);
    chk("idle_done", title_done, 8'd0);

    // 2: fade in
    pulse_start;
    chk("fin_busy", busy, 8'd1);
    chk("fin_level0", level, 8'd0);
    frames(13);
    chk("fin_level6", level, 8'd6);
    frames(1);
    chk("fin_level7", level, 8'd7);
    chk("fin_red7", red, 8'h7);
    chk("fin_green7", green, 8'h4);
    chk("fin_blue7", blue, 8'h0);
    frames(15);
    chk("fin_level14", level, 8'd14);
    frames(1);
    chk("hold_level", level, 8'd15);
    chk("hold_busy", busy, 8'd1);
    chk("hold_red", red, 8'hF);
    chk("hold_green", green, 8'h8);
    chk("hold_blue", blue, 8'h1);
    in_red = 4'h5;
    @(negedge vga_clk);
    chk("latency_red", red, 8'h5);
    in_red = 4'hF;
    @(negedge vga_clk);

    // 3: key_go early dropped, then honoured; fade out to DONE
    frames(1);
    pulse_go;
    frames(2);
    chk("go_early_level", level, 8'd15);
    pulse_go;
    frames(2);
    chk("fout_level14", level, 8'd14);
    frames(28);
    chk("done_level", level, 8'd0);
    chk("done_flag", title_done, 8'd1);
    chk("done_busy", busy, 8'd0);
    chk("done_red", red, 8'h0);

    // 6c: start in DONE restarts
    pulse_start;
    chk("restart_done", title_done, 8'd0);
    chk("restart_busy", busy, 8'd1);

    // 4: skip at level 5
    frames(10);
    chk("skip_pre_level", level, 8'd5);
    pulse_skip;
    chk("skip_level", level, 8'd15);
    // 6b: start in HOLD ignored
    pulse_start;
    frames(3);
    chk("hold_start_level", level, 8'd15);
    chk("hold_start_busy", busy, 8'd1);
    pulse_go;
    frames(12);
    chk("fout_level9", level, 8'd9);
    chk("fout_red9", red, 8'h9);

    // 5: async reset mid fade-out
    @(negedge vga_clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_red", red, 8'h0);
    chk("arst_level", level, 8'd0);
    chk("arst_busy", busy, 8'd0);
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge vga_clk);
    chk("post_rst_level", level, 8'd0);
    pulse_start;
    chk("post_rst_busy", busy, 8'd1);
    frames(2);
    chk("post_rst_level1", level, 8'd1);
    chk("post_rst_red1", red, 8'h1);

    // 4b: skip coincident with tick, hold counter must start at 0
    @(negedge vga_clk); vs = 1'b0; skip = 1'b1;
    @(negedge vga_clk); skip = 1'b0;
    repeat (2) @(negedge vga_clk);
    vs = 1'b1;
    repeat (16) @(negedge vga_clk);
    chk("skiptick_level", level, 8'd15);
    frames(2);
    pulse_go;
    frames(2);
    chk("skiptick_hold0", level, 8'd15);

    // 6a: vs held low gives one tick
    pulse_go;
    @(negedge vga_clk); vs = 1'b0;
    repeat (100) @(negedge vga_clk);
    vs = 1'b1;
    repeat (5) @(negedge vga_clk);
    chk("vslow_level", level, 8'd15);
    frames(1);
    chk("vslow_level14", level, 8'd14);

    // skip in FADE_OUT
    pulse_skip;
    chk("fout_skip_level", level, 8'd0);
    chk("fout_skip_done", title_done, 8'd1);
    chk("fout_skip_busy", busy, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
